// File: rtl/task_out_pkg.sv
// Shared definitions for the task_out return path: the per-task parameter
// table (tasks_params_array[].DATA_WIDTH_OUT), the FSM state enum, the
// decoded sample-width selector and the host word size.
package task_out_pkg;

  localparam int TASK_OUT_WORD_BYTES = 4;
  localparam int NUM_TASKS           = 8;
  localparam int TASK_IDX_W          = 3;

  typedef enum logic [1:0] {
    s_IDLE,
    s_COLLECT,
    s_DRAIN,
    s_DONE
  } task_out_state_e;

  // Decoded output sample width; WSEL_BAD covers every unsupported width.
  typedef enum logic [1:0] {
    WSEL_8,
    WSEL_16,
    WSEL_32,
    WSEL_BAD
  } width_sel_e;

  typedef struct packed {
    logic [7:0] DATA_WIDTH_OUT;
  } task_params_t;

  // Task 3 (12 bits) and task 7 (0 bits) are deliberately unsupported widths.
  localparam task_params_t tasks_params_array [NUM_TASKS] = '{
    '{DATA_WIDTH_OUT: 8'd32},
    '{DATA_WIDTH_OUT: 8'd8},
    '{DATA_WIDTH_OUT: 8'd16},
    '{DATA_WIDTH_OUT: 8'd12},
    '{DATA_WIDTH_OUT: 8'd8},
    '{DATA_WIDTH_OUT: 8'd16},
    '{DATA_WIDTH_OUT: 8'd32},
    '{DATA_WIDTH_OUT: 8'd0}
  };

  // Look up the running task's output width; out-of-range indices are unsupported.
  function automatic width_sel_e task_width_sel(input logic [31:0] task_number);
    width_sel_e sel;
    logic [7:0] w;
    sel = WSEL_BAD;
    w   = 8'd0;
    if (task_number < 32'(NUM_TASKS)) begin
      w = tasks_params_array[task_number[TASK_IDX_W-1:0]].DATA_WIDTH_OUT;
    end
    case (w)
      8'd8:    sel = WSEL_8;
      8'd16:   sel = WSEL_16;
      8'd32:   sel = WSEL_32;
      default: sel = WSEL_BAD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/task_out_if.sv
// Host-side AXI-Stream link of task_out. The master drives data/valid/last,
// the slave drives ready.
interface task_out_if;

  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_tlast;

  modport master (
    output o_tdata,
    output o_tvalid,
    output o_tlast,
    input  i_tready
  );

  modport slave (
    input  o_tdata,
    input  o_tvalid,
    input  o_tlast,
    output i_tready
  );

endinterface

// File: rtl/task_out_packer.sv
// Little-endian sample packer: places 8/16/32-bit samples into lanes of a
// 32-bit word, emits a push when the lane wraps or on the frame's last
// sample, and records how many bytes the final word carries.
module task_out_packer
  import task_out_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        sample_en,
  input  width_sel_e  width_sel,
  input  logic [31:0] sample,
  input  logic        sample_last,
  output logic        push,
  output logic        push_last,
  output logic [31:0] push_word,
  output logic [31:0] num_valid_bytes
);

  logic [1:0]  lane;
  logic [31:0] acc;
  logic [31:0] lane_bits;
  logic        lane_wrap;
  logic [2:0]  last_bytes;

  // Position the incoming sample in its lane and decide whether the word is complete.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    lane_bits  = '0;
    lane_wrap  = 1'b1;
    last_bytes = 3'(TASK_OUT_WORD_BYTES);
    case (width_sel)
      WSEL_8: begin
        lane_bits  = {24'd0, sample[7:0]} << {lane, 3'b000};
        lane_wrap  = (lane == 2'd3);
        last_bytes = 3'(lane) + 3'd1;
      end
      WSEL_16: begin
        lane_bits  = {16'd0, sample[15:0]} << {lane[0], 4'b0000};
        lane_wrap  = lane[0];
        last_bytes = lane[0] ? 3'd4 : 3'd2;
      end
      WSEL_32: begin
        lane_bits  = sample;
        lane_wrap  = 1'b1;
        last_bytes = 3'(TASK_OUT_WORD_BYTES);
      end
      default: begin
        lane_bits  = '0;
        lane_wrap  = 1'b1;
        last_bytes = 3'(TASK_OUT_WORD_BYTES);
      end
    endcase
  end

  assign push_word = acc | lane_bits;
  assign push      = sample_en && (lane_wrap || sample_last);
  assign push_last = sample_en && sample_last;

  // Advance the lane / accumulator and capture the final-word byte count.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      lane            <= '0;
      acc             <= '0;
      num_valid_bytes <= '0;
    end else if (sample_en) begin
      if (push) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + 2'd1;
        acc  <= push_word;
      end
      if (sample_last) begin
        num_valid_bytes <= 32'(last_bytes);
      end
    end
  end

endmodule

// File: rtl/task_out.sv
// task_out: return path of the task datapath. Packs task samples into
// 32-bit words, stores a whole frame in a FIFO, then streams it to the host
// over AXI-Stream with tlast and pulses o_output_last when it is gone.
// Optional feature: define TASK_OUT_OVERFLOW_FLAG_EN to get a sticky
// o_overflow flag for dropped words/samples; otherwise o_overflow is 0.
module task_out
  import task_out_pkg::*;
#(
  parameter int FIFO_DEPTH_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       current_task_number,
  input  logic [31:0]       i_data,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic              i_last,
  task_out_if.master        axis,
  output logic [31:0]       o_num_valid_bytes_in_last_sample,
  output logic              o_output_last,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH_WORDS);
  localparam int CNT_W = PTR_W + 1;

  task_out_state_e state, state_next;
  width_sel_e      width_sel;

  logic        sample_ok;
  logic        pk_push, pk_last;
  logic [31:0] pk_word;

  logic [32:0]      mem [FIFO_DEPTH_WORDS];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_wr, fifo_rd;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;

  // Frames start on any valid sample, so i_first carries no information here.
  logic unused_first;
  assign unused_first = i_first;

  assign width_sel = task_width_sel(current_task_number);
  assign sample_ok = i_valid && (width_sel != WSEL_BAD) &&
                     ((state == s_IDLE) || (state == s_COLLECT));

  task_out_packer u_packer (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .sample_en       (sample_ok),
    .width_sel       (width_sel),
    .sample          (i_data),
    .sample_last     (i_last),
    .push            (pk_push),
    .push_last       (pk_last),
    .push_word       (pk_word),
    .num_valid_bytes (o_num_valid_bytes_in_last_sample)
  );

  // One entry is held back for the frame's last word, so it can never be refused.
  assign fifo_wr = pk_push && (pk_last || (count != CNT_W'(FIFO_DEPTH_WORDS - 1)));
  assign fifo_rd = (state == s_DRAIN) && (count != '0) && (!out_valid || axis.i_tready);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= s_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and frame-done pulse.
  always_comb begin
    state_next    = state;
    o_output_last = (state == s_DONE);
    case (state)
      s_IDLE: begin
        if (sample_ok) begin
          state_next = i_last ? s_DRAIN : s_COLLECT;
        end
      end
      s_COLLECT: begin
        if (sample_ok && i_last) begin
          state_next = s_DRAIN;
        end
      end
      s_DRAIN: begin
        if (out_valid && axis.i_tready && out_last) begin
          state_next = s_DONE;
        end
      end
      s_DONE: begin
        state_next = s_IDLE;
      end
      default: begin
        state_next = s_IDLE;
      end
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the storage array is not reset; pointers and count alone define which entries are live.
    if (fifo_wr) begin
      mem[wr_ptr] <= {pk_last, pk_word};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register: refill when empty or when the current word is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (fifo_rd) begin
      out_data  <= mem[rd_ptr][31:0];
      out_last  <= mem[rd_ptr][32];
      out_valid <= 1'b1;
    end else if (out_valid && axis.i_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign axis.o_tdata  = out_data;
  assign axis.o_tvalid = out_valid;
  assign axis.o_tlast  = out_last;

`ifdef TASK_OUT_OVERFLOW_FLAG_EN
  logic drop;
  logic overflow_q;

  // A drop is a rejected sample (bad width or wrong state) or a refused FIFO push.
  assign drop = (i_valid && !sample_ok) || (pk_push && !fifo_wr);

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule
